// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory command port between N_REQ requesters.
// Registered outputs throughout; a watchdog turns a stuck WAIT into an error ack.
module mem_port_arbiter #(
  parameter int N_REQ   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic                err,
  output logic                mem_start,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  input  logic                mem_done,
  output logic                busy
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     win, cand;
  logic              found;
  logic              timeout;

  logic [N_REQ-1:0]  ack_d;
  logic [DW-1:0]     rdata_d;
  logic              err_d;
  logic              mem_start_d;
  logic              mem_we_d;
  logic [AW-1:0]     mem_addr_d;
  logic [DW-1:0]     mem_wdata_d;
  logic              busy_d;

  // Scan upward from the slot after the last winner, wrapping once.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(last_q) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign timeout = (TIMEOUT != 0) && (state_q == WAIT) &&
                   !mem_done && (cnt_q == CLAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      last_q    <= GW'(N_REQ - 1);
      grant_q   <= '0;
      cnt_q     <= '0;
      ack       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      mem_start <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      ack       <= ack_d;
      rdata     <= rdata_d;
      err       <= err_d;
      mem_start <= mem_start_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_done || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d      = last_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    rdata_d     = rdata;
    err_d       = 1'b0;
    mem_start_d = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    busy_d      = (state_d != IDLE);
    unique case (1'b1)
      (state_q == IDLE): begin
        if (found) begin
          last_d      = win;
          grant_d     = win;
          mem_start_d = 1'b1;
          mem_we_d    = req_we[win];
          mem_addr_d  = req_addr[win*AW +: AW];
          mem_wdata_d = req_wdata[win*DW +: DW];
        end
      end
      (state_q == ISSUE): cnt_d = '0;
      (state_q == WAIT): begin
        if (mem_done) begin
          rdata_d = mem_rdata;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == RESP) ack_d[grant_q] = 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected acks queued at
// stimulus time, popped and compared whenever the DUT pulses ack.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [1:0]  req, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        err, mem_start, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done;

  typedef struct packed {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   npass = 0;

  mem_port_arbiter #(
    .N_REQ(2), .AW(32), .DW(32), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .err(err),
    .mem_start(mem_start), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1 && ack !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", {62'd0, ack}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ack", {62'd0, ack}, {62'd0, e.ack});
        chk("sb_rdata", {32'd0, rdata}, {32'd0, e.rdata});
        chk("sb_err", {63'd0, err}, {63'd0, e.err});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ack"}, {62'd0, ack}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_start"}, {63'd0, mem_start}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_we"}, {63'd0, mem_we}, 64'd0);
    chk({tag, "_addr"}, {32'd0, mem_addr}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
    chk({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
  endtask

  // One transfer from IDLE; dly = cycles from start to done (0 = never).
  task automatic xfer(input int i, input bit we,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int dly, input logic [31:0] rd,
                      input bit spur);
    int c, d, expc;
    exp_t e;
    logic [1:0] oh;
    oh = (i == 1) ? 2'b10 : 2'b01;
    d = (dly > 0) ? dly + 1 : -1;
    expc = (dly > 0) ? d + 1 : 2 + TO;
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = wd;
    e.ack = oh;
    e.rdata = (dly > 0) ? rd : 32'd0;
    e.err = (dly == 0);
    sb.push_back(e);
    step();
    c = 1;
    chk("start", {63'd0, mem_start}, 64'd1);
    chk("start_addr", {32'd0, mem_addr}, {32'd0, a});
    chk("start_we", {63'd0, mem_we}, {63'd0, we});
    chk("start_wdata", {32'd0, mem_wdata}, {32'd0, wd});
    mem_done = spur;
    mem_rdata = 32'hBAD0_BAD0;
    while (c < 40) begin
      step();
      c++;
      mem_done = 1'b0;
      if (ack !== 2'b00) break;
      chk("wait_start", {63'd0, mem_start}, 64'd0);
      chk("wait_addr", {32'd0, mem_addr}, {32'd0, a});
      if (c == d) begin
        mem_done = 1'b1;
        mem_rdata = rd;
      end
    end
    chk("ack_cycle", c, expc);
    chk("ack_who", {62'd0, ack}, {62'd0, oh});
    chk("ack_addr", {32'd0, mem_addr}, {32'd0, a});
    chk("ack_we", {63'd0, mem_we}, {63'd0, we});
    chk("ack_wdata", {32'd0, mem_wdata}, {32'd0, wd});
    req[i] = 1'b0;
    step();
    chk("post_busy", {63'd0, busy}, 64'd0);
    chk("post_hold_addr", {32'd0, mem_addr}, {32'd0, a});
  endtask

  // Both requesters held; memory answers one cycle after each start.
  task automatic serve(input logic [1:0] pat, input int n,
                       input logic [3:0] order, input logic [31:0] base);
    int got, c;
    bit pend;
    exp_t e;
    got = 0;
    c = 0;
    pend = 1'b0;
    req_we = 2'b00;
    req_addr = {32'h20, 32'h10};
    for (int k = 0; k < n; k++) begin
      e.ack = order[k] ? 2'b10 : 2'b01;
      e.rdata = base + 32'(k);
      e.err = 1'b0;
      sb.push_back(e);
    end
    req = pat;
    while (got < n && c < 80) begin
      step();
      c++;
      mem_done = 1'b0;
      if (pend) begin
        mem_done = 1'b1;
        mem_rdata = base + 32'(got);
        pend = 1'b0;
      end
      if (mem_start) begin
        chk("grant_addr", {32'd0, mem_addr},
            order[got] ? 64'h20 : 64'h10);
        pend = 1'b1;
      end
      if (ack !== 2'b00) begin
        got++;
        if (got == n) req = 2'b00;
      end
    end
    chk("serve_count", got, n);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    mem_rdata = '0;
    mem_done = 1'b0;
    step();
    step();
    chk_idle_outs("reset");
    RST_N = 1'b1;
    step();

    xfer(0, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    xfer(1, 1'b1, 32'h2004, 32'h12345678, 3, 32'h55AA, 1'b0);
    xfer(0, 1'b0, 32'h500, 32'h0, 0, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h504, 32'h0, 1, 32'hCAFE0001, 1'b0);

    mem_done = 1'b1;
    mem_rdata = 32'h1111;
    step();
    mem_done = 1'b0;
    chk("spur_idle_busy", {63'd0, busy}, 64'd0);
    chk("spur_idle_start", {63'd0, mem_start}, 64'd0);
    step();
    xfer(0, 1'b0, 32'h700, 32'h0, 3, 32'h0BADF00D, 1'b1);

    req[0] = 1'b1;
    req_addr[31:0] = 32'h600;
    step();
    step();
    step();
    #2;
    RST_N = 1'b0;
    req = 2'b00;
    #1;
    chk_idle_outs("rst_wait");
    step();
    chk_idle_outs("rst_hold");
    RST_N = 1'b1;
    step();
    serve(2'b11, 2, 4'b0010, 32'hB0000000);
    serve(2'b10, 1, 4'b0001, 32'hC0000000);
    serve(2'b11, 4, 4'b1010, 32'hA0000000);

    step();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
